// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock with one registered carry.
// Start/busy/done handshake; result, carry-out and signed overflow are held until the next completion.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    if (WIDTH == 0 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be non-zero and divide WIDTH exactly");
    end

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic [DIGIT:0]   digit_sum;
    logic             last;

    // Result digits enter at the top, so after N shifts the LSB digit sits at bit 0.
    always_comb begin
        digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_next  = (res_sr >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last      = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= sub ? ~b : b;
                        res_sr <= '0;
                        // Subtraction is a + ~b + 1; c_in only matters when adding.
                        carry  <= sub | c_in;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    carry  <= digit_sum[DIGIT];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum       <= res_next;
                        carry_out <= digit_sum[DIGIT];
                        overflow  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operations on several WIDTH/DIGIT instances,
// compared against a plain-arithmetic reference of a + b' + carry0.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // WIDTH=8, DIGIT=1
    logic       start8, sub8, cin8, busy8, done8, co8, ov8;
    logic [7:0] a8, b8, sum8;
    serial_adder #(.WIDTH(8), .DIGIT(1)) u_add8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
    );

    // WIDTH=1, DIGIT=1
    logic       start1, sub1, cin1, busy1, done1, co1, ov1;
    logic [0:0] a1, b1, sum1;
    serial_adder #(.WIDTH(1), .DIGIT(1)) u_add1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1)
    );

    // WIDTH=16 with DIGIT 1, 2, 4, 16 sharing the same inputs
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic [3:0]  busy16, done16, co16, ov16;
    logic [15:0] s16 [4];
    serial_adder #(.WIDTH(16), .DIGIT(1)) u_add16_d1 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
        .busy(busy16[0]), .done(done16[0]), .sum(s16[0]), .carry_out(co16[0]),
        .overflow(ov16[0])
    );
    serial_adder #(.WIDTH(16), .DIGIT(2)) u_add16_d2 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
        .busy(busy16[1]), .done(done16[1]), .sum(s16[1]), .carry_out(co16[1]),
        .overflow(ov16[1])
    );
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_add16_d4 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
        .busy(busy16[2]), .done(done16[2]), .sum(s16[2]), .carry_out(co16[2]),
        .overflow(ov16[2])
    );
    serial_adder #(.WIDTH(16), .DIGIT(16)) u_add16_d16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
        .busy(busy16[3]), .done(done16[3]), .sum(s16[3]), .carry_out(co16[3]),
        .overflow(ov16[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry_out, sum} of a w-bit add of x + y' + carry0.
    function automatic logic [17:0] model(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s,
                                          input logic ci);
        longint mask, yp, t;
        logic   ov, co;
        mask = (longint'(1) << w) - 1;
        yp   = s ? (~longint'(y) & mask) : longint'(y);
        t    = longint'(x) + yp + (s ? longint'(1) : longint'(ci));
        co   = t[w];
        ov   = (x[w-1] == yp[w-1]) && (t[w-1] != x[w-1]);
        return {ov, co, 16'(t & mask)};
    endfunction

    // Launch one 8-bit op and wait for done; leaves time at the done cycle.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic ci, input bit scramble);
        logic [17:0] m;
        int          lat;
        bit          busy_ok;
        a8 = x; b8 = y; sub8 = s; cin8 = ci; start8 = 1'b1;
        tick();
        start8  = 1'b0;
        m       = model(8, {8'h00, x}, {8'h00, y}, s, ci);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done8 && lat < 20) begin
            if (!busy8) busy_ok = 1'b0;
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); cin8 = 1'($urandom);
            end
            tick();
            lat++;
        end
        chk("lat8", lat, 8);
        chk("busy8_during_run", 32'(busy_ok), 1);
        chk("busy8_at_done", 32'(busy8), 0);
        chk("sum8", 32'(sum8), 32'(m[7:0]));
        chk("carry8", 32'(co8), 32'(m[16]));
        chk("ovf8", 32'(ov8), 32'(m[17]));
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input logic ci);
        logic [17:0] m;
        int          lat [4];
        int          exp_lat [4];
        exp_lat = '{16, 8, 4, 1};
        lat     = '{-1, -1, -1, -1};
        a16 = x; b16 = y; sub16 = s; cin16 = ci; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        m = model(16, x, y, s, ci);
        for (int c = 1; c <= 20; c++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            tick();
            for (int k = 0; k < 4; k++) if (done16[k] && lat[k] < 0) lat[k] = c;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lat16[%0d]", k), lat[k], exp_lat[k]);
            chk($sformatf("sum16[%0d]", k), 32'(s16[k]), 32'(m[15:0]));
            chk($sformatf("carry16[%0d]", k), 32'(co16[k]), 32'(m[16]));
            chk($sformatf("ovf16[%0d]", k), 32'(ov16[k]), 32'(m[17]));
        end
    endtask

    initial begin
        logic [17:0] m;
        int          seen;
        rst = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        #1;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_sum", 32'(sum8), 0);
        chk("rst_carry", 32'(co8), 0);
        chk("rst_ovf", 32'(ov8), 0);
        #22 rst = 1'b0;
        tick();

        // Directed vectors
        run8(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);
        chk("5a+3c+1_sum", 32'(sum8), 32'h97);
        chk("5a+3c+1_ovf", 32'(ov8), 1);
        chk("done8_high", 32'(done8), 1);
        tick();
        chk("done8_pulse_width", 32'(done8), 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("ff+01_carry", 32'(co8), 1);
        tick();
        run8(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        chk("10-20_sum", 32'(sum8), 32'hF0);
        tick();
        run8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        chk("80-01_ovf", 32'(ov8), 1);
        tick();

        // start pulses at E2 and E5 during RUN must be ignored
        a8 = 8'h11; b8 = 8'h22; sub8 = 0; cin8 = 0; start8 = 1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            start8 = (i == 2 || i == 5);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            tick();
        end
        start8 = 0;
        chk("ignore_done", 32'(done8), 1);
        chk("ignore_sum", 32'(sum8), 32'h33);
        tick();
        chk("ignore_no_queue_busy", 32'(busy8), 0);
        chk("ignore_no_queue_done", 32'(done8), 0);

        // Back-to-back: second start issued on the done cycle
        run8(8'h42, 8'h17, 1'b0, 1'b0, 1'b0);
        run8(8'hC3, 8'h5E, 1'b1, 1'b0, 1'b0);
        tick();

        // Asynchronous reset between E3 and E4
        a8 = 8'h7F; b8 = 8'h7F; sub8 = 0; cin8 = 1; start8 = 1;
        tick();
        start8 = 0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy8), 0);
        chk("midrst_done", 32'(done8), 0);
        chk("midrst_sum", 32'(sum8), 0);
        chk("midrst_carry", 32'(co8), 0);
        #10 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("post_rst_sum", 32'(sum8), 32'h02);
        tick();

        // Random 8-bit ops with operands scrambled during RUN
        for (int i = 0; i < 25; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        tick();

        // Exhaustive WIDTH=1 add
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); sub1 = 0; start1 = 1;
            tick();
            start1 = 0;
            tick();
            m = model(1, {15'h0, a1}, {15'h0, b1}, 1'b0, cin1);
            chk($sformatf("w1_done[%0d]", i), 32'(done1), 1);
            chk($sformatf("w1_sum[%0d]", i), 32'(sum1), 32'(m[0]));
            chk($sformatf("w1_carry[%0d]", i), 32'(co1), 32'(m[16]));
            chk($sformatf("w1_fa_sum[%0d]", i), 32'(sum1), 32'(i[2] ^ i[1] ^ i[0]));
        end

        // WIDTH=16 across DIGIT values
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("ffff+0001_sum", 32'(s16[2]), 0);
        chk("ffff+0001_carry", 32'(co16[2]), 1);
        for (int i = 0; i < 30; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
